// File: rtl/xilinx_fifo_rd_stream_pkg.sv
// fifo_rd_pkg: shared types and depth helper for the FIFO read-stream adapter
//   lvl_t    : 3-bit level/credit count, 0..DEPTH
//   depth_of : buffer depth for a given FIFO read latency
package fifo_rd_pkg;
  typedef logic [2:0] lvl_t;
  function automatic int depth_of(input int rd_latency);
    return rd_latency + 2;
  endfunction
endpackage

// File: rtl/xilinx_fifo_rd_stream_if.sv
// xilinx_fifo_rd_stream_if: valid/ready output stream of the read adapter
//   m_data  : stream data, DSIZE bits
//   m_valid : stream valid
//   m_ready : stream ready
interface xilinx_fifo_rd_stream_if #(parameter int DSIZE = 128);
  logic [DSIZE-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master(output m_data, m_valid, input m_ready);
  modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/xilinx_fifo_rd_stream_skid_ram.sv
// fifo_rd_skid_ram: DEPTH x DSIZE prefetch buffer with wrapping pointers and level
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata at the write pointer
//   i_pop      : consume the head word (ignored while empty)
//   o_rdata    : head word, o_valid : buffer not empty, o_level : words held
module fifo_rd_skid_ram
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 128,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DSIZE-1:0] i_wdata,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_valid,
  output lvl_t             o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  lvl_t r_level;
  logic w_pop;
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_pop = i_pop && (r_level != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_valid = r_level != '0;
  assign o_level = r_level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem <= '{default: '0};
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
      if (i_push) r_wptr <= wrap_inc(r_wptr);
      if (w_pop) r_rptr <= wrap_inc(r_rptr);
      r_level <= r_level + lvl_t'(i_push) - lvl_t'(w_pop);
    end
  // Credit accounting in the parent keeps pushes from ever landing on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && (r_level == lvl_t'(DEPTH))));
endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// xilinx_fifo_rd_stream: turns a fixed-latency FIFO read port into a valid/ready stream
//   clk, rst_n  : FIFO read clock, asynchronous active-low reset
//   fifo_empty  : FIFO empty flag, fifo_rd_en : FIFO read strobe
//   fifo_dout   : FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   m           : output stream (m_data, m_valid, m_ready)
//   level       : words currently buffered, 0..DEPTH
module xilinx_fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 128,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DSIZE-1:0]        fifo_dout,
  xilinx_fifo_rd_stream_if.master m,
  output lvl_t                    level
);
  localparam int DEPTH = depth_of(RD_LATENCY);
  logic [RD_LATENCY-1:0] r_pipe;
  lvl_t r_inflight;
  lvl_t w_credit;
  logic w_push;
  logic w_pop;
  // Credit counts both buffered words and reads still in the FIFO pipeline, so a read
  // is only issued when its data is guaranteed a slot; m_ready never reaches rd_en.
  assign w_credit = level + r_inflight;
  // Gating with rst_n keeps the strobe low while the adapter is held in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && (w_credit < lvl_t'(DEPTH));
  assign w_push = r_pipe[RD_LATENCY-1];
  assign w_pop = m.m_valid && m.m_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pipe <= '0;
      r_inflight <= '0;
    end else begin
      r_pipe <= RD_LATENCY'({r_pipe, fifo_rd_en});
      r_inflight <= r_inflight + lvl_t'(fifo_rd_en) - lvl_t'(w_push);
    end
  fifo_rd_skid_ram #(.DSIZE(DSIZE), .DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(fifo_dout),
    .o_rdata(m.m_data),
    .o_valid(m.m_valid),
    .o_level(level)
  );
endmodule

// File: doc/xilinx_fifo_rd_stream.md
# xilinx_fifo_rd_stream

Read-side adapter placed directly after the `xilinx_fifo` wrapper, in the read clock domain. It converts the FIFO's standard-mode read port into a valid/ready stream: `empty` and `dout` in, `rd_en` out, with `dout` arriving a fixed latency after `rd_en`. A small prefetch buffer sustains one word per cycle under continuous `m_ready`, and no combinational path runs from `m_ready` to `fifo_rd_en`.

## Interface
- `DSIZE`, 128: data width; must equal the attached FIFO's `DSIZE`.
- `RD_LATENCY`, 1: cycles from `fifo_rd_en` high to valid `fifo_dout`; legal values are 1 and 2.
- `clk`  in  1: FIFO read clock (`rd_clk`).
- `rst_n`  in  1: reset, asynchronous and active-low.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO read strobe.
- `fifo_dout`  in  DSIZE: FIFO read data.
- `m_data`  out  DSIZE: stream data.
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready.
- `level`  out  3: words held in the buffer, 0..DEPTH.

## Operation
- Buffer depth: `DEPTH = RD_LATENCY + 2` (3 or 4 entries). This is the minimum depth for full throughput without a ready-to-rd_en path.
- Credit count: `credit = level + inflight`, where `inflight` is the number of issued reads not yet returned (0..RD_LATENCY). Both terms are registered.
- Read issue: `fifo_rd_en = !fifo_empty && (credit < DEPTH)`. This is combinational from `fifo_empty` and registers only.
- Return tracking: a shift register of length RD_LATENCY carries `fifo_rd_en`. When its output is 1, `fifo_dout` is written at `wptr`.
- Pop: occurs when `m_valid && m_ready`, and advances `rptr`.
- Output: `m_valid = (level != 0)`; `m_data = mem[rptr]`.
- Pointers: `wptr` and `rptr` wrap modulo DEPTH. `level` is updated as +push −pop; a simultaneous push and pop leaves it unchanged.
- No overflow is possible by construction: a push with `level == DEPTH` and no pop is an assertion failure.
- Pop with `level == 0` is ignored.
- Reset, asynchronous and active-low:
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `level`=0.
  - Pointers, inflight count, latency shift register and mem all reset to 0.
- Reset mid-operation: in-flight reads are discarded. This block must be reset together with the FIFO read side.
- Contract on the attached FIFO: `fifo_empty`=1 whenever the FIFO would ignore `rd_en`, including its post-reset warm-up.

## Timing
- First word: `fifo_empty` falls at cycle t, so `fifo_rd_en`=1 at t. Data is captured at t+RD_LATENCY and `m_valid`=1 at t+RD_LATENCY+1.
- Steady state with `m_ready`=1 and the FIFO non-empty:
  - one `fifo_rd_en` per cycle and one pop per cycle;
  - `level` settles at 1 (RD_LATENCY=1).
- Backpressure: `m_ready`=0 with `m_valid`=1 holds `m_data` stable. `fifo_rd_en` stops once `credit == DEPTH`, and at most DEPTH words are buffered.
- Ready reasserted after a full stall: pops resume the same cycle. `fifo_rd_en` reasserts the next cycle, once registered `credit` has dropped below DEPTH.
- FIFO goes empty mid-burst: `fifo_rd_en` falls the same cycle. The buffer drains, and `m_valid` falls the cycle after the last pop.

## Structure
- Shared package `fifo_rd_pkg`:
  - `localparam` function `depth_of(RD_LATENCY)`;
  - typedef for the 3-bit level/credit type.
- One natural sub-module, `fifo_rd_skid_ram`: DEPTH×DSIZE register array with write/read pointers, wrap logic and `level`. The top level holds the credit, inflight and latency-pipe logic.
- No other hierarchy.

## Test plan
- Reset release with `fifo_empty`=1 for 20 cycles -> `fifo_rd_en`, `m_valid` and `level` stay 0.
- FIFO preloaded with 0x01..0x10 (16 words), `m_ready`=1 constantly, RD_LATENCY=1 -> first `m_valid` 2 cycles after `fifo_empty` falls; words then appear on 16 consecutive cycles, in order, with no bubbles.
- Same load, `m_ready`=0 -> exactly 3 `fifo_rd_en` pulses, `level`=3, `m_data`=0x01 held. Raising `m_ready` drains 0x01..0x10 in order.
- Random `m_ready` (50%) and random `fifo_empty` over 10k words, for both RD_LATENCY=1 and RD_LATENCY=2 -> scoreboard matches, `level` ≤ DEPTH, no overflow assertion.
- `rst_n` pulsed low while `level`=2 and one read is in flight -> all outputs are 0 asynchronously. After release, only newly written words appear.
- Single word 0xA5 written, `m_ready`=1 -> one `m_valid` cycle carrying 0xA5, then `m_valid`=0 and `level`=0.
